// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared constants and width helpers for the pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int c_DATA_WIDTH = 32;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fifo_mem
// Description : DEPTH x DATA_WIDTH register array, one synchronous write port
//               and one combinational read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fifo_mem
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      i_wr_en,
    input  logic [ptr_w(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [ptr_w(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/pipeline_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_fifo
// Description : Elastic valid/ready FIFO stage with occupancy count,
//               almost-full flag and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_fifo
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full
);

    localparam int c_CW = cnt_w(DEPTH);
    localparam int c_PW = ptr_w(DEPTH);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AFULL = c_CW'(AFULL_THRESH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "pipeline_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
            $fatal(1, "pipeline_fifo: AFULL_THRESH must be in 1..DEPTH");
        end
        if (DATA_WIDTH < 1) begin : g_bad_width
            $fatal(1, "pipeline_fifo: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [c_CW-1:0]       r_count;
    logic [c_PW-1:0]       r_rd_ptr;
    logic [c_PW-1:0]       r_wr_ptr;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Flags come only from registered count, so in_ready never sees out_ready.
    assign in_ready    = (r_count != c_FULL);
    assign out_valid   = (r_count != '0);
    assign almost_full = (r_count >= c_AFULL);
    assign count       = r_count;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign out_data    = out_valid ? w_rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    pipeline_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push && !flush),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_fifo
// Description : Self-checking bench for pipeline_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_fifo;

    localparam int c_DW    = 32;
    localparam int c_DEPTH = 4;
    localparam int c_AF    = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [c_DW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [c_DW-1:0] out_data;
    logic [2:0]      count;
    logic            almost_full;

    int checks = 0;
    int errors = 0;

    logic [c_DW-1:0] q[$];

    pipeline_fifo #(
        .DATA_WIDTH   (c_DW),
        .DEPTH        (c_DEPTH),
        .AFULL_THRESH (c_AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: accepts when not full, emits when not empty, flush/reset empty it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else if (in_valid && q.size() != c_DEPTH) begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            q.push_back(in_data);
        end else if (q.size() != 0 && out_ready) begin
            void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("m_in_ready", 64'(in_ready), 64'(q.size() != c_DEPTH));
        chk("m_almost_full", 64'(almost_full), 64'(q.size() >= c_AF));
        if (q.size() != 0) chk("m_out_data", 64'(out_data), 64'(q[0]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [c_DW-1:0] exp_bp [5];

    initial begin
        exp_bp[0] = 32'h1; exp_bp[1] = 32'h2; exp_bp[2] = 32'h3;
        exp_bp[3] = 32'h4; exp_bp[4] = 32'hDEAD_BEEF;

        step(); step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b0;

        // single transfer
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        step();
        in_valid = 1'b0;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_data), 64'hA5A5_0001);
        chk("single_count1", 64'(count), 64'd1);
        step();
        chk("single_count0", 64'(count), 64'd0);

        // backpressure fill
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            chk("bp_count", 64'(count), 64'(i));
            chk("bp_afull", 64'(almost_full), 64'(i >= 3));
            chk("bp_in_ready", 64'(in_ready), 64'(i != 4));
        end
        in_data = 32'hDEAD_BEEF;
        step();
        chk("bp_hold_count", 64'(count), 64'd4);
        chk("bp_hold_head", 64'(out_data), 64'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_order", 64'(out_data), 64'(exp_bp[k]));
            step();
            if (k == 1) in_valid = 1'b0;
        end
        chk("bp_drained", 64'(count), 64'd0);

        // full throughput
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'h1234_5678 + 32'(i);
            step();
            chk("tp_count", 64'(count), 64'd1);
            chk("tp_in_ready", 64'(in_ready), 64'd1);
            chk("tp_data", 64'(out_data), 64'(32'h1234_5678 + 32'(i)));
        end
        in_valid = 1'b0;
        step();
        chk("tp_empty", 64'(count), 64'd0);

        // simultaneous push/pop at count=2, eight cycles to wrap pointers
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h10; step();
        in_data = 32'h11; step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'hCAFE_0000 + 32'(i);
            step();
            chk("pp_count", 64'(count), 64'd2);
            if (i == 0) chk("pp_head", 64'(out_data), 64'h11);
            else        chk("pp_head", 64'(out_data), 64'(32'hCAFE_0000 + 32'(i - 1)));
        end
        in_valid = 1'b0;
        step();
        chk("pp_tail", 64'(out_data), 64'hCAFE_0007);
        step();
        chk("pp_empty", 64'(count), 64'd0);

        // flush with concurrent push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h31 + 32'(i); step();
        end
        chk("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        step(); step();
        chk("fl_stays_empty", 64'(out_valid), 64'd0);

        // async reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h61; step();
        in_data = 32'h62; step();
        in_valid = 1'b0;
        chk("ar_pre_count", 64'(count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", 64'(count), 64'd0);
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h5A5A_5A5A;
        step();
        in_valid = 1'b0;
        chk("ar_first_valid", 64'(out_valid), 64'd1);
        chk("ar_first_data", 64'(out_data), 64'h5A5A_5A5A);
        step();
        chk("ar_final_count", 64'(count), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
